mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multicycle memory controller that serves the load/store requests of the multicycle control unit.
- Holds a word-addressed data array and models a fixed access latency.
- Returns a one-cycle done pulse, which the control unit's memory states wait on.
- Sits directly downstream of the control unit / datapath memory-address path; rdata feeds the memory-data register ahead of the mem_to_reg mux.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 32, byte-address width
DEPTH, 256, number of words in the array; power of two, minimum 2
LATENCY, 4, cycles from request acceptance to done; minimum 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  read request, level; held by requester until done
mem_write  input  1  write request, level; held by requester until done
addr  input  ADDR_W  byte address
wdata  input  DATA_W  store data
rdata  output  DATA_W  registered load data, held between reads
done  output  1  one-cycle completion pulse
busy  output  1  high while an access is in flight (ACCESS state)
align_err  output  1  high together with done when the completed access was misaligned

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (async assert, applies at any time including mid-access):
  - state=IDLE; done=0, busy=0, align_err=0, rdata=0, counter=0.
  - An in-flight write that has not yet reached its commit edge is dropped.
  - The array is not cleared by reset; in simulation it powers up to all zeros.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - At a rising edge with mem_write|mem_read=1: latch addr, wdata and op, then go to ACCESS with counter=LATENCY-1.
  - Write has priority when both requests are high.
- ACCESS, each edge:
  - counter!=0: decrement and stay.
  - counter==0: commit the access and go to DONE.
  - Requests and addr/wdata changing during ACCESS are ignored; the latched values are used.
- Commit rules:
  - Word index = latched addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH.
  - Aligned write: array[index] <= wdata.
  - Aligned read: rdata <= array[index].
  - Misaligned access (latched addr[1:0]!=0): no array write, rdata unchanged, align_err set for the DONE cycle.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - The next edge always returns to IDLE. A request sampled in DONE is not accepted, which gives the requester one cycle to drop or change its request.
- Outputs:
  - done = (state==DONE); busy = (state==ACCESS).
  - align_err is 0 outside DONE.
- Latency: the request is accepted at edge E; done is high in the cycle following edge E+LATENCY.
  - LATENCY=1: done appears in the cycle after the second edge.
- Throughput: back-to-back requests held high complete at best every LATENCY+2 cycles (one IDLE cycle, LATENCY ACCESS edges, one DONE cycle).
- Read-after-write: a read issued after a write to the same word sees the new data. The write commits before done, and a later read cannot be accepted before DONE.
- rdata holds its value across writes, misaligned reads and idle cycles.

Test Plan:
- Reset, then aligned write/read at LATENCY=4: write mem_write=1, addr=0x10, wdata=0xDEADBEEF; then read mem_read=1, addr=0x10.
  - Each done comes 4 edges after acceptance and is exactly one cycle wide; busy is high for 4 cycles.
  - rdata=0xDEADBEEF on the read's done cycle.
- Wrap, DEPTH=256: write 0x12345678 to addr=0x400, then read addr=0x000 -> rdata=0x12345678.
- Misaligned access, array word 4 preloaded with 0xAAAA5555:
  - Write 0xFFFFFFFF to addr=0x13 -> done and align_err both high for one cycle.
  - Then aligned read of 0x10 -> rdata=0xAAAA5555 (no write occurred).
- Simultaneous requests: mem_read=1 and mem_write=1, addr=0x20, wdata=0x1 -> treated as a write; a subsequent read of 0x20 returns 0x1 and rdata was unchanged in between.
- Reset mid-access: write 0xCAFEF00D to addr=0x30; pulse rst_n low 2 edges after acceptance.
  - Outputs immediately go to 0; no done is produced.
  - A later read of 0x30 returns the prior contents (0).
- Held request: mem_read held high continuously for 20 cycles at LATENCY=2.
  - done pulses exactly every 4 cycles.
  - Request is never accepted in the DONE cycle; busy and done are never high together.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Multicycle word-addressed memory with fixed access latency and a one-cycle done pulse.
// Serves load/store requests from the multicycle control unit; rdata feeds the memory-data register.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              align_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LAT_W = IDX_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  index;
    logic              aligned;
    logic              commit;
    logic              mem_we;

    // Address bits above the array index wrap out of range addresses modulo DEPTH.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDR_W-1:LAT_W];

    assign index   = addr_q[LAT_W-1:2];
    assign aligned = (addr_q[1:0] == 2'b00);
    assign commit  = (state_q == ACCESS) && (cnt_q == '0);
    assign mem_we  = commit && write_q && aligned;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    addr_d  = addr[LAT_W-1:0];
                    wdata_d = wdata;
                    write_d = mem_write;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    if (!write_q && aligned) begin
                        rdata_d = mem_q[index];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // The array is deliberately not reset; a write only lands on its commit edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[index] <= wdata_q;
        end
    end

    assign rdata     = rdata_q;
    assign done      = (state_q == DONE);
    assign busy      = (state_q == ACCESS);
    assign align_err = (state_q == DONE) && !aligned;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a reference model pushes expected results into a
// scoreboard at issue time, and they are popped and compared when done pulses.
module tb_mem_access_ctrl;

    localparam int LAT  = 4;
    localparam int LAT2 = 2;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        alignErr;
    } expect_t;

    logic        clk;
    logic        rstN;
    logic        memRead, memWrite;
    logic [31:0] addr, wdata, rdata;
    logic        done, busy, alignErr;

    logic        memRead2, memWrite2;
    logic [31:0] addr2, wdata2, unusedRdata2;
    logic        done2, busy2, unusedAlignErr2;

    expect_t     scoreboard[$];
    logic [31:0] modelMem [256];
    logic [31:0] modelRdata;
    int          checkCount;
    int          errorCount;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rstN), .mem_read(memRead), .mem_write(memWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .align_err(alignErr)
    );

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT2)) dut2 (
        .clk(clk), .rst_n(rstN), .mem_read(memRead2), .mem_write(memWrite2),
        .addr(addr2), .wdata(wdata2), .rdata(unusedRdata2), .done(done2), .busy(busy2),
        .align_err(unusedAlignErr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one request, holds it until done, and compares timing plus the scoreboard entry.
    task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                                 input logic [31:0] a, input logic [31:0] d);
        expect_t e;
        expect_t got;
        int      cycles;
        int      busyCycles;
        bit      seenDone;
        logic    isAligned;
        isAligned = (a[1:0] == 2'b00);
        if (wr && isAligned) modelMem[a[9:2]] = d;
        if (!wr && isAligned) modelRdata = modelMem[a[9:2]];
        e.tag      = tag;
        e.rdata    = modelRdata;
        e.alignErr = !isAligned;
        scoreboard.push_back(e);

        @(negedge clk);
        memWrite = wr;
        memRead  = rd;
        addr     = a;
        wdata    = d;
        cycles     = 0;
        busyCycles = 0;
        seenDone   = 0;
        while (!seenDone && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                addr  = $urandom;
                wdata = $urandom;
            end
            if (done) seenDone = 1;
            else if (busy) busyCycles++;
        end
        memWrite = 1'b0;
        memRead  = 1'b0;
        checkOutput({tag, ":done_seen"}, 32'(seenDone), 32'd1);
        got = scoreboard.pop_front();
        if (seenDone) begin
            checkOutput({got.tag, ":latency"}, cycles, LAT + 1);
            checkOutput({got.tag, ":busy_cycles"}, busyCycles, LAT);
            checkOutput({got.tag, ":rdata"}, rdata, got.rdata);
            checkOutput({got.tag, ":align_err"}, 32'(alignErr), 32'(got.alignErr));
            @(negedge clk);
            checkOutput({got.tag, ":done_width"}, 32'(done), 32'd0);
            checkOutput({got.tag, ":align_err_after"}, 32'(alignErr), 32'd0);
        end
    endtask

    initial begin
        int doneCount;
        int firstDone;
        int lastDone;
        int gapErrs;
        int overlapErrs;
        int acceptErrs;
        int spuriousDone;
        bit prevDone;

        checkCount = 0;
        errorCount = 0;
        modelRdata = '0;
        for (int i = 0; i < 256; i++) modelMem[i] = '0;
        rstN = 1'b0;
        memRead = 0;  memWrite = 0;  addr = 0;  wdata = 0;
        memRead2 = 0; memWrite2 = 0; addr2 = 0; wdata2 = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset:done", 32'(done), 32'd0);
        checkOutput("reset:busy", 32'(busy), 32'd0);
        checkOutput("reset:align_err", 32'(alignErr), 32'd0);
        checkOutput("reset:rdata", rdata, 32'd0);
        rstN = 1'b1;

        applyStimulus("wr_0x10", 1, 0, 32'h10, 32'hDEADBEEF);
        applyStimulus("rd_0x10", 0, 1, 32'h10, 32'h0);

        applyStimulus("wr_wrap_0x400", 1, 0, 32'h400, 32'h12345678);
        applyStimulus("rd_wrap_0x000", 0, 1, 32'h000, 32'h0);

        applyStimulus("preload_0x10", 1, 0, 32'h10, 32'hAAAA5555);
        applyStimulus("wr_misaligned_0x13", 1, 0, 32'h13, 32'hFFFFFFFF);
        applyStimulus("rd_after_misaligned", 0, 1, 32'h10, 32'h0);
        applyStimulus("rd_misaligned_0x22", 0, 1, 32'h22, 32'h0);

        applyStimulus("both_req_0x20", 1, 1, 32'h20, 32'h1);
        applyStimulus("rd_0x20", 0, 1, 32'h20, 32'h0);

        // Known contents at 0x30 so the aborted write has a defined "prior" value.
        applyStimulus("clear_0x30", 1, 0, 32'h30, 32'h0);
        @(negedge clk);
        memWrite = 1'b1;
        addr     = 32'h30;
        wdata    = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midreset:busy_before", 32'(busy), 32'd1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midreset:done", 32'(done), 32'd0);
        checkOutput("midreset:busy", 32'(busy), 32'd0);
        checkOutput("midreset:align_err", 32'(alignErr), 32'd0);
        checkOutput("midreset:rdata", rdata, 32'd0);
        modelRdata = '0;
        memWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        spuriousDone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) spuriousDone++;
        end
        checkOutput("midreset:no_done", spuriousDone, 0);
        applyStimulus("rd_0x30_after_abort", 0, 1, 32'h30, 32'h0);

        // Held read on the LATENCY=2 instance: done every 4 cycles, never re-accepted in DONE.
        doneCount = 0; firstDone = -1; lastDone = -1;
        gapErrs = 0; overlapErrs = 0; acceptErrs = 0; prevDone = 0;
        @(negedge clk);
        memRead2 = 1'b1;
        addr2    = 32'h0;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            if (busy2 && done2) overlapErrs++;
            if (prevDone && busy2) acceptErrs++;
            if (done2) begin
                if (firstDone < 0) firstDone = s;
                else if (s - lastDone != LAT2 + 2) gapErrs++;
                lastDone = s;
                doneCount++;
            end
            prevDone = done2;
        end
        memRead2 = 1'b0;
        checkOutput("held:first_done", firstDone, LAT2 + 1);
        checkOutput("held:done_count", doneCount, 5);
        checkOutput("held:gap", gapErrs, 0);
        checkOutput("held:busy_done_overlap", overlapErrs, 0);
        checkOutput("held:accept_in_done", acceptErrs, 0);

        checkOutput("scoreboard:empty", scoreboard.size(), 0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
